log_shift_norm: RTL

- Front-end normalizer for the 4-bit-fraction PE log datapath.
- Accepts unsigned operands on a valid/ready stream and detects the leading one.
- Drives the 4-bit shift offset into the downstream registered log-offset LUT (1-cycle latency, no enable).
- Delays the normalized mantissa, exponent and zero flag so they leave in the same cycle as the matching LUT output, including across downstream back-pressure.

---
 rtl/log_shift_norm.sv | 84 ++++++++
 1 files changed

// File: rtl/log_shift_norm.sv
// Leading-one normalizer feeding a registered log-offset LUT; mantissa, exponent
// and zero flag are delayed two stages so they emerge alongside the LUT output.
module log_shift_norm #(
  parameter int DATA_W = 16,
  parameter int OFF_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [OFF_W-1:0]  shift_offset,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OFF_W-1:0]  out_exp,
  output logic [DATA_W-2:0] out_frac,
  output logic              out_zero
);

  function automatic logic [OFF_W-1:0] lead_one(input logic [DATA_W-1:0] d);
    lead_one = '0;
    for (int i = 0; i < DATA_W; i++)
      if (d[i]) lead_one = OFF_W'(i);
  endfunction

  function automatic logic [DATA_W-2:0] norm_frac(input logic [DATA_W-1:0] d,
                                                  input logic [OFF_W-1:0]  msb);
    logic [DATA_W-1:0] n;
    n = d << (DATA_W - 1 - int'(msb));
    norm_frac = n[DATA_W-2:0];
  endfunction

  logic              vld_p1, vld_p2;
  logic [OFF_W-1:0]  off_p1, off_p2;
  logic [DATA_W-2:0] frac_p1, frac_p2;
  logic              zero_p1, zero_p2;
  logic              adv;
  logic [OFF_W-1:0]  msb_p0;

  assign adv      = ~vld_p2 | out_ready;
  assign in_ready = ~vld_p1 | adv;
  assign msb_p0   = lead_one(in_data);

  // While stalled the LUT re-samples the held offset so its output stays matched to stage 2.
  assign shift_offset = adv ? off_p1 : off_p2;

  // Stage 1: leading-one detect and normalize
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      off_p1  <= '0;
      frac_p1 <= '0;
      zero_p1 <= 1'b0;
    end else if (in_ready) begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        off_p1  <= msb_p0;
        frac_p1 <= norm_frac(in_data, msb_p0);
        zero_p1 <= (in_data == '0);
      end
    end
  end

  // Stage 2: align with the registered LUT output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      off_p2  <= '0;
      frac_p2 <= '0;
      zero_p2 <= 1'b0;
    end else if (adv) begin
      vld_p2  <= vld_p1;
      off_p2  <= off_p1;
      frac_p2 <= frac_p1;
      zero_p2 <= zero_p1;
    end
  end

  assign out_valid = vld_p2;
  assign out_exp   = off_p2;
  assign out_frac  = frac_p2;
  assign out_zero  = zero_p2;

endmodule
